gpio_uart_tx: RTL and testbench
===============================

GPIO_UART_TX -- requirements
Module: gpio_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 The block SHALL have parameter DEPTH, default 16, number of FIFO byte entries; power of two, at least 2.
REQ-003 The block SHALL have port clk  input  1  single system clock, rising-edge active.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port GPIO  input  8  output byte from the processor memory controller.
REQ-006 The block SHALL have port GPIOEn  input  1  write strobe; each clk cycle it is high is one byte write.
REQ-007 The block SHALL have port tx  output  1  UART serial line, idle high.
REQ-008 The block SHALL have port busy  output  1  high while a frame is in flight or the FIFO is non-empty.
REQ-009 The block SHALL have port full  output  1  high when the FIFO count equals DEPTH.
REQ-010 The block SHALL have port overflow  output  1  sticky flag for a dropped write.
REQ-011 The block SHALL have port count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-012 The FIFO SHALL be circular, with wrapping read and write pointers of $clog2(DEPTH) bits, and count SHALL be updated at the same edge as each push or pop.
REQ-013 A write with count<DEPTH SHALL push GPIO at that rising edge.
REQ-014 A write with count==DEPTH and no pop at the same edge SHALL be dropped and SHALL set overflow to 1; overflow SHALL clear only on reset.
REQ-015 A write with count==DEPTH and a pop at the same edge SHALL be accepted, leaving count unchanged.
REQ-016 The transmitter FSM SHALL have states IDLE, START, DATA, PARITY and STOP; PARITY exists only per REQ-027.
REQ-017 IDLE: tx=1; if count>0, the FSM SHALL pop the head byte into an 8-bit shift register and enter START at the same edge.
REQ-018 START: tx=0 for CLKS_PER_BIT cycles, then the FSM SHALL enter DATA.
REQ-019 DATA: the FSM SHALL send 8 bits LSB first, each for CLKS_PER_BIT cycles, using a 3-bit bit counter; after bit 7 it SHALL enter PARITY (macro defined) or STOP.
REQ-020 STOP: tx=1 for CLKS_PER_BIT cycles; on the last cycle, if count>0 the FSM SHALL pop and enter START directly with no idle gap, otherwise it SHALL enter IDLE.
REQ-021 tx SHALL be driven from a flop; a byte written into an empty FIFO at edge N SHALL drive tx low from edge N+1.
REQ-022 The baud counter SHALL restart at every state or bit transition.
REQ-023 busy SHALL equal (state!=IDLE) OR (count!=0), decoded from registered state.
REQ-024 A write arriving during a frame SHALL NOT disturb the frame in progress.

Reset
REQ-025 On rst low, asynchronously and independent of clk: state=IDLE, tx=1, pointers=0, count=0, full=0, overflow=0, busy=0, baud and bit counters=0.
REQ-026 Assertion mid-frame SHALL abort the frame immediately, discard FIFO contents, and leave no partial frame after release; normal operation SHALL resume at the first clk edge after rst returns high.

Configuration
REQ-027 Macro GPIO_TX_PARITY_EN:
- Defined: PARITY state follows DATA, drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles; frame = 11 bits.
- Undefined: PARITY state and its logic are absent, DATA goes directly to STOP, frame = 10 bits.

Verification
REQ-028 (CLKS_PER_BIT=4, DEPTH=16) Single write 0xA5 at edge N -> tx low from N+1; bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy falls at N+41; count returns to 0 at N+1.
REQ-029 18 consecutive writes of 0x01..0x12 from empty -> byte 0x01 popped at the second edge; 0x01..0x11 accepted; 0x12 dropped; full=1 and count=16 after the 18th edge; overflow=1 and stays 1.
REQ-030 Writes 0x00 then 0xFF on consecutive cycles -> the second frame's start bit begins at the edge immediately after the first frame's 4-cycle stop bit, with no idle cycle between frames.
REQ-031 rst low mid-DATA with 3 bytes queued -> tx=1, count=0, busy=0, overflow=0 immediately, without a clock edge; no frame after release until a new write.
REQ-032 With GPIO_TX_PARITY_EN defined, write 0x07 -> parity bit 1 after data bit 7, then stop bit; write 0x03 -> parity bit 0; frame length 44 cycles.

Source files
------------

// File: rtl/gpio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_uart_tx
//  Description : Byte FIFO fed by a processor GPIO write strobe, drained by
//                an 8-bit UART transmitter. The line is idle high. Each frame
//                is one start bit, eight data bits sent LSB first, and one
//                stop bit. When the FIFO still holds data, frames follow each
//                other back to back.
//
//  Build option: GPIO_TX_PARITY_EN
//                Define this macro to insert an even-parity bit between the
//                data bits and the stop bit. The frame is then 11 bits.
//
//  Parameters  : CLKS_PER_BIT  clock cycles per serial bit (2..65535)
//                DEPTH         FIFO entries, power of two, >= 2
//
//  Ports       : clk        rising-edge system clock
//                rst        asynchronous active-low reset
//                GPIO[7:0]  byte to transmit
//                GPIOEn     write strobe, one byte per high cycle
//                tx         UART serial output, driven from a flop
//                busy       frame in flight or FIFO non-empty
//                full       FIFO occupancy equals DEPTH
//                overflow   sticky: a write was dropped (cleared by reset)
//                count      FIFO occupancy
//
//  Revision    : 1.0  initial release
// ============================================================================
module gpio_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               GPIO,
    input  logic                     GPIOEn,
    output logic                     tx,
    output logic                     busy,
    output logic                     full,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int               c_AW        = $clog2(DEPTH);
    localparam logic [c_AW:0]    c_FULL      = (c_AW+1)'(DEPTH);
    localparam logic [15:0]      c_BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef GPIO_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_overflow;

    // Transmitter
    state_t          r_state;
    logic            r_tx;
    logic [15:0]     r_baud;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
`ifdef GPIO_TX_PARITY_EN
    logic            r_parity;
`endif

    logic            w_baud_done;
    logic            w_not_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic [7:0]      w_head;

    assign w_baud_done = (r_baud == c_BAUD_LAST);
    assign w_not_empty = (r_count != '0);
    assign w_full      = (r_count == c_FULL);
    assign w_head      = r_mem[r_rd_ptr];

    // The transmitter takes the head byte either from IDLE or on the last
    // cycle of a stop bit, which is what makes consecutive frames gapless.
    assign w_pop  = w_not_empty &&
                    ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_done));
    // A full FIFO still accepts a write when a slot frees at the same edge.
    assign w_push = GPIOEn && (!w_full || w_pop);

    // ------------------------------------------------------------------
    // FIFO pointers, occupancy and overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (GPIOEn && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= GPIO;
        end
    end

    // ------------------------------------------------------------------
    // Transmitter FSM. tx is registered and updated on the same edge as
    // the state change, so the line switches exactly at the bit boundary.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_tx     <= 1'b1;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
`ifdef GPIO_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_baud <= '0;
                    r_bit  <= '0;
                    if (w_pop) begin
                        r_shift  <= w_head;
`ifdef GPIO_TX_PARITY_EN
                        r_parity <= ^w_head;
`endif
                        r_state  <= S_START;
                        r_tx     <= 1'b0;
                    end
                end

                S_START: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end

                S_DATA: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_bit   <= '0;
`ifdef GPIO_TX_PARITY_EN
                            r_state <= S_PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            // Bit 1 of the current shift value is the next
                            // bit to go out once the register shifts.
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end

`ifdef GPIO_TX_PARITY_EN
                S_PARITY: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
`endif

                S_STOP: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift  <= w_head;
`ifdef GPIO_TX_PARITY_EN
                            r_parity <= ^w_head;
`endif
                            r_state  <= S_START;
                            r_tx     <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_baud  <= '0;
                    r_bit   <= '0;
                end
            endcase
        end
    end

    assign tx       = r_tx;
    assign busy     = (r_state != S_IDLE) || w_not_empty;
    assign full     = w_full;
    assign overflow = r_overflow;
    assign count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_gpio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_uart_tx
//  Description : Self-checking bench for gpio_uart_tx (CLKS_PER_BIT=4,
//                DEPTH=16). A table of per-cycle vectors covers one complete
//                frame. Hand-written sequences cover back-to-back frames,
//                FIFO overflow, a write while full with a simultaneous pop,
//                reset during a frame and, when GPIO_TX_PARITY_EN is
//                defined, the parity bit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gpio_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
`ifdef GPIO_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME = FB * CPB;

    logic       clk;
    logic       rst;
    logic [7:0] GPIO;
    logic       GPIOEn;
    logic       tx, busy, full, overflow;
    logic [4:0] count;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    gpio_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .GPIO     (GPIO),
        .GPIOEn   (GPIOEn),
        .tx       (tx),
        .busy     (busy),
        .full     (full),
        .overflow (overflow),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       en;
        logic [7:0] d;
        logic       e_tx;
        logic       e_busy;
        logic       e_full;
        logic       e_ovf;
        logic [4:0] e_cnt;
    } vec_t;

    vec_t tbl [46];
    logic seq [FB];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Serial receiver: samples each bit at its middle cycle, on negedges.
    task automatic recv(output logic [7:0] b, output logic p, output int t0, output bit ok);
        int w;
        ok = 1'b1; b = '0; p = 1'b0; t0 = 0; w = 0;
        @(negedge clk);
        while (tx !== 1'b0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (tx !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        t0 = cyc;
        repeat (6) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            b[k] = tx;
            if (k < 7) repeat (4) @(negedge clk);
        end
`ifdef GPIO_TX_PARITY_EN
        repeat (4) @(negedge clk);
        p = tx;
`endif
        repeat (4) @(negedge clk);
        if (tx !== 1'b1) ok = 1'b0;
        @(negedge clk);  // last stop cycle; the next start may follow directly
    endtask

    task automatic wait_idle(input string name);
        int w = 0;
        while (busy !== 1'b0 && w < 3000) begin
            tick();
            w++;
        end
        chk(name, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] b1, b2;
        logic       p1, p2;
        int         t1, t2;
        bit         ok1, ok2;
        bit         bad;

        // Hand-derived line sequence for 0xA5: start, 1,0,1,0,0,1,0,1, [parity 0], stop
`ifdef GPIO_TX_PARITY_EN
        seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif
        tbl[0] = '{en: 1'b1, d: 8'hA5, e_tx: 1'b1, e_busy: 1'b1, e_full: 1'b0, e_ovf: 1'b0, e_cnt: 5'd1};
        for (int i = 1; i <= FRAME; i++)
            tbl[i] = '{en: 1'b0, d: 8'h00, e_tx: seq[(i-1)/4], e_busy: 1'b1, e_full: 1'b0, e_ovf: 1'b0, e_cnt: 5'd0};
        tbl[FRAME+1] = '{en: 1'b0, d: 8'h00, e_tx: 1'b1, e_busy: 1'b0, e_full: 1'b0, e_ovf: 1'b0, e_cnt: 5'd0};

        GPIO = 8'h00; GPIOEn = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("reset_state", {27'd0, tx, busy, full, overflow, count[0]}, {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        chk("reset_count", {27'd0, count}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        // ---- Table: single 0xA5 frame, one vector per clock ----
        for (int i = 0; i <= FRAME + 1; i++) begin
            GPIOEn = tbl[i].en;
            GPIO   = tbl[i].d;
            tick();
            GPIOEn = 1'b0;
            chk($sformatf("frame_vec%0d", i),
                {23'd0, tx, busy, full, overflow, count},
                {23'd0, tbl[i].e_tx, tbl[i].e_busy, tbl[i].e_full, tbl[i].e_ovf, tbl[i].e_cnt});
        end

        // ---- Back-to-back frames 0x00 then 0xFF, no idle gap ----
        fork
            begin
                GPIOEn = 1'b1; GPIO = 8'h00; tick();
                GPIO = 8'hFF; tick();
                GPIOEn = 1'b0;
            end
            begin
                recv(b1, p1, t1, ok1);
                recv(b2, p2, t2, ok2);
            end
        join
        chk("b2b_rx_ok", {30'd0, ok1, ok2}, 32'd3);
        chk("b2b_byte1", {24'd0, b1}, 32'h00);
        chk("b2b_byte2", {24'd0, b2}, 32'hFF);
        chk("b2b_gap", t2 - t1, FRAME);
        wait_idle("b2b_idle");

        // ---- Overflow: 18 writes, then a write while full with a pop ----
        fork
            begin
                for (int k = 1; k <= 18; k++) begin
                    GPIOEn = 1'b1; GPIO = 8'(k); tick();
                    if (k == 1)  chk("ovf_cnt_e1", {27'd0, count}, 32'd1);
                    if (k == 2)  chk("ovf_cnt_e2", {27'd0, count}, 32'd1);
                    if (k == 17) chk("ovf_e17", {29'd0, full, overflow, count[4]}, {29'd0, 1'b1, 1'b0, 1'b1});
                end
                GPIOEn = 1'b0;
                chk("ovf_e18", {26'd0, full, overflow, count}, {26'd0, 1'b1, 1'b1, 5'd16});
                // Frame 1 started at edge 2, so its last stop cycle pops at edge 2+FRAME.
                repeat (FRAME - 17) tick();
                chk("full_before_pop", {27'd0, count}, 32'd16);
                GPIOEn = 1'b1; GPIO = 8'h13; tick();
                GPIOEn = 1'b0;
                chk("full_push_pop", {26'd0, full, overflow, count}, {26'd0, 1'b1, 1'b1, 5'd16});
            end
            begin
                for (int j = 0; j < 18; j++) begin
                    recv(b1, p1, t1, ok1);
                    bad = !ok1 || (b1 !== ((j < 17) ? 8'(j + 1) : 8'h13));
                    if (bad) chk($sformatf("ovf_rx%0d", j), {23'd0, ok1, b1}, {23'd1, ((j < 17) ? 8'(j + 1) : 8'h13)});
                    else     n_vec++;
                end
            end
        join
        wait_idle("ovf_drain_idle");
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // ---- Reset mid-DATA with 3 bytes queued ----
        GPIOEn = 1'b1;
        GPIO = 8'h55; tick();
        GPIO = 8'h66; tick();
        GPIO = 8'h77; tick();
        GPIO = 8'h88; tick();
        GPIOEn = 1'b0;
        repeat (10) tick();
        chk("pre_reset_count", {27'd0, count}, 32'd3);
        #2 rst = 1'b0;
        #1;
        chk("async_reset", {23'd0, tx, busy, full, overflow, count}, {23'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0});
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0 || count !== 5'd0) bad = 1'b1;
        end
        chk("no_frame_after_reset", {31'd0, bad}, 32'd0);

        // ---- Normal operation resumes ----
        fork
            begin GPIOEn = 1'b1; GPIO = 8'h3C; tick(); GPIOEn = 1'b0; end
            recv(b1, p1, t1, ok1);
        join
        chk("resume_byte", {23'd0, ok1, b1}, {23'd1, 8'h3C});
        wait_idle("resume_idle");

`ifdef GPIO_TX_PARITY_EN
        // ---- Parity bit: 0x07 has odd weight, 0x03 even ----
        fork
            begin
                GPIOEn = 1'b1; GPIO = 8'h07; tick();
                GPIO = 8'h03; tick();
                GPIOEn = 1'b0;
            end
            begin
                recv(b1, p1, t1, ok1);
                recv(b2, p2, t2, ok2);
            end
        join
        chk("par_rx", {14'd0, ok1, ok2, b1, b2}, {14'd0, 1'b1, 1'b1, 8'h07, 8'h03});
        chk("par_07", {31'd0, p1}, 32'd1);
        chk("par_03", {31'd0, p2}, 32'd0);
        chk("par_len", t2 - t1, 44);
        wait_idle("par_idle");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
